// File: rtl/rr_arbiter_3to8.sv
// rr_arbiter_3to8: round-robin arbiter for eight requesters sharing one
// 3:8 decoded resource. It issues a registered one-hot grant plus its encoded
// index, limits each grant to MAX_HOLD cycles and inserts GAP_CYCLES dead
// cycles after every release so the shared lines can turn around.
module rr_arbiter_3to8 #(
    parameter int unsigned MAX_HOLD   = 16,  // 1..255
    parameter int unsigned GAP_CYCLES = 1    // 0..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [3:0] GAP_C      = 4'(GAP_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    logic       busy_q, busy_d;

    logic       win_found_s;
    logic [2:0] win_idx_s;

    // First set request bit searching upward from the pointer, wrapping 7->0.
    // Returns {found, index}.
    function automatic logic [3:0] find_winner(input logic [7:0] req_v,
                                               input logic [2:0] ptr_v);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_v + 3'(i);
            if (!found && req_v[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Round-robin winner for the current request vector and pointer.
    always_comb begin
        {win_found_s, win_idx_s} = find_winner(req, ptr_q);
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d = 8'h00;
                if (en && win_found_s) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 8'h01 << win_idx_s;
                    gnt_idx_d  = win_idx_s;
                    hold_cnt_d = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_idx_q] || (hold_cnt_q >= MAX_HOLD_C)) begin
                    // A release wins over a simultaneous hold expiry.
                    timeout_d = req[gnt_idx_q];
                    gnt_d     = 8'h00;
                    ptr_d     = gnt_idx_q + 3'd1;
                    if (GAP_C != 4'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_C;
                    end else begin
                        state_d   = ST_IDLE;
                        gap_cnt_d = 4'd0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                gnt_d = 8'h00;
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = 8'h00;
                gap_cnt_d = 4'd0;
            end
        endcase

        gnt_valid_d = |gnt_d;
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gap_cnt_q   <= 4'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter_3to8.sv
// Bench for rr_arbiter_3to8 (MAX_HOLD=4, GAP_CYCLES=2). Directed stimulus
// queues the grants it expects; a monitor pops them as grants appear and
// checks index, length, timeout pulse and dead-gap length.
module tb_rr_arbiter_3to8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        int         len;   // expected high cycles, 0 = not checked
        bit         tmo;   // grant must end with a timeout pulse
        int         gap;   // expected low cycles before it, -1 = not checked
    } item_t;

    item_t exp_q[$];

    rr_arbiter_3to8 #(.MAX_HOLD(4), .GAP_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] g, input logic [2:0] i, input int len,
                        input bit tmo, input int gap);
        item_t it;
        it.gnt = g; it.idx = i; it.len = len; it.tmo = tmo; it.gap = gap;
        exp_q.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor state
    bit         in_grant = 1'b0;
    bit         ended;
    item_t      cur;
    int         cur_len  = 0;
    int         low_cnt  = 0;
    logic [2:0] last_idx = 3'd0;

    // Scoreboard monitor: samples outputs on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_grant = 1'b0;
            last_idx = 3'd0;
            low_cnt  = 0;
        end else begin
            check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
            check("onehot", 32'($countones(gnt) <= 1), 32'd1);
            ended = 1'b0;
            if (!in_grant) begin
                if (gnt != 8'h00) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got gnt=%0h with none expected", gnt);
                        cur.gnt = gnt; cur.idx = gnt_idx; cur.len = 0; cur.tmo = 1'b0; cur.gap = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        check("gnt_start", 32'(gnt), 32'(cur.gnt));
                        check("idx_start", 32'(gnt_idx), 32'(cur.idx));
                        if (cur.gap >= 0) check("gap_len", low_cnt, cur.gap);
                    end
                    check("busy_grant", 32'(busy), 32'd1);
                    in_grant = 1'b1;
                    cur_len  = 1;
                end else begin
                    check("idx_hold", 32'(gnt_idx), 32'(last_idx));
                    low_cnt++;
                end
            end else begin
                if (gnt != 8'h00) begin
                    check("gnt_stable", 32'(gnt), 32'(cur.gnt));
                    check("busy_grant", 32'(busy), 32'd1);
                    cur_len++;
                end else begin
                    ended    = 1'b1;
                    in_grant = 1'b0;
                    if (cur.len > 0) check("grant_len", cur_len, cur.len);
                    check("busy_gap", 32'(busy), 32'd1);
                    last_idx = cur.idx;
                    check("idx_hold", 32'(gnt_idx), 32'(last_idx));
                    low_cnt  = 1;
                end
            end
            check("timeout", 32'(timeout), 32'(ended ? cur.tmo : 1'b0));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single requester, hold 3 cycles then drop
        en = 1'b1; req = 8'h01; push(8'h01, 3'd0, 3, 1'b0, -1);
        tick();
        check("t1_gnt", 32'(gnt), 32'h01);
        check("t1_idx", 32'(gnt_idx), 32'h0);
        tick(); tick(); req = 8'h00;
        tick();
        check("t1_rel", 32'(gnt), 32'h00);
        check("t1_busy", 32'(busy), 32'h1);
        tick(); tick(); tick();

        // 2: all requesting from reset, rotation 0..7,0 by timeout
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++)
            push(8'(8'h01 << (k % 8)), 3'(k % 8), 4, 1'b1, (k == 0) ? -1 : 3);
        repeat (63) tick();
        req = 8'h00;
        tick(); tick();
        check("t2_idle", 32'(busy), 32'h0);

        // 3: wrap-around, ptr 1 -> grant 2, then ptr 3 with req 05 -> 0
        req = 8'h04; push(8'h04, 3'd2, 2, 1'b0, -1);
        tick();
        check("t3_gnt2", 32'(gnt), 32'h04);
        tick(); req = 8'h00;
        tick();
        check("t3_rel", 32'(gnt), 32'h00);
        req = 8'h05; push(8'h01, 3'd0, 1, 1'b0, 3);
        tick(); tick(); tick();
        check("t3_wrap_gnt", 32'(gnt), 32'h01);
        check("t3_wrap_idx", 32'(gnt_idx), 32'h0);
        req = 8'h00;
        tick(); tick(); tick(); tick();

        // 4: holder drops exactly when hold count reaches MAX_HOLD
        req = 8'h02; push(8'h02, 3'd1, 4, 1'b0, -1);
        tick();
        check("t4_gnt", 32'(gnt), 32'h02);
        tick(); tick(); tick(); req = 8'h00;
        tick();
        check("t4_rel", 32'(gnt), 32'h00);
        check("t4_no_tmo", 32'(timeout), 32'h0);
        tick(); tick(); tick();

        // 5: async reset mid-grant, then req 80 from ptr 0
        req = 8'h10; push(8'h10, 3'd4, 0, 1'b0, -1);
        tick();
        check("t5_gnt", 32'(gnt), 32'h10);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'h00);
        check("t5_async_valid", 32'(gnt_valid), 32'h0);
        check("t5_async_busy", 32'(busy), 32'h0);
        check("t5_async_idx", 32'(gnt_idx), 32'h0);
        req = 8'h80;
        tick();
        rst_n = 1'b1;
        push(8'h80, 3'd7, 2, 1'b0, -1);
        tick();
        check("t5_gnt80", 32'(gnt), 32'h80);
        check("t5_idx7", 32'(gnt_idx), 32'h7);
        tick(); req = 8'h00;
        tick();
        check("t5_rel", 32'(gnt), 32'h00);
        tick(); tick(); tick();

        // 6: en blocks new grants only
        en = 1'b0; req = 8'h08;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_blocked", 32'(gnt), 32'h00);
        end
        en = 1'b1; push(8'h08, 3'd3, 4, 1'b1, -1);
        tick();
        check("t6_gnt", 32'(gnt), 32'h08);
        en = 1'b0;
        tick(); tick(); tick();
        check("t6_hold", 32'(gnt), 32'h08);
        tick();
        check("t6_cut", 32'(gnt), 32'h00);
        check("t6_tmo", 32'(timeout), 32'h1);
        req = 8'h00;
        tick(); tick(); tick(); tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
